// File: rtl/mandelbrot_frame_scheduler_pkg.sv
// Purpose : shared types and constants for the Mandelbrot frame scheduler.
// Latency : n/a (declarations only).
// Backpres: n/a.
//
// Contents: scheduler state enum, fixed-point fraction-bit constant/helper and
// the values forced into a pixel result when the engine times out.
package mandelbrot_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    // Coordinates are S II . F : one sign bit, two integer bits, rest fraction.
    localparam int DEFAULT_FP_WIDTH = 32;
    localparam int FRAC_BITS        = DEFAULT_FP_WIDTH - 3;

    function automatic int frac_bits(input int fp_width);
        return fp_width - 3;
    endfunction

    // A timed-out pixel is reported as "in set" with a saturated count, which
    // the colour path renders the same as a point that never escaped.
    localparam logic [31:0] TIMEOUT_ITER   = '1;
    localparam logic        TIMEOUT_IN_SET = 1'b1;

endpackage

// File: rtl/mandelbrot_coord_walker.sv
// Purpose : raster-order x/y counters and c_real/c_imag accumulators.
// Latency : load/advance take effect on the next clock edge.
// Backpres: none; advances only when the scheduler pulses i_advance.
//
// Ports: i_load latches origin/step and resets to pixel (0,0); i_advance
// steps one pixel (column wrap moves down one row, imaginary decreases).
// o_last_col / o_last_pixel flag the end of a row / frame.
module mandelbrot_coord_walker
    import mandelbrot_frame_scheduler_pkg::*;
#(
    parameter int FPW   = 32,
    parameter int H_RES = 64,
    parameter int V_RES = 48,
    parameter int XW    = 6,
    parameter int YW    = 6
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           i_load,
    input  logic           i_advance,
    input  logic [FPW-1:0] i_origin_real,
    input  logic [FPW-1:0] i_origin_imag,
    input  logic [FPW-1:0] i_step,
    output logic [XW-1:0]  o_x,
    output logic [YW-1:0]  o_y,
    output logic [FPW-1:0] o_cur_real,
    output logic [FPW-1:0] o_cur_imag,
    output logic           o_last_col,
    output logic           o_last_pixel
);

    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [FPW-1:0] r_cur_real;
    logic [FPW-1:0] r_cur_imag;
    logic [FPW-1:0] r_org_real;
    logic [FPW-1:0] r_step;
    logic           w_last_col;
    logic           w_last_row;

    assign w_last_col = (r_x == XW'(H_RES - 1));
    assign w_last_row = (r_y == YW'(V_RES - 1));

    // Plain two's-complement adds; wraparound is intended, no saturation.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_cur_real <= '0;
            r_cur_imag <= '0;
            r_org_real <= '0;
            r_step     <= '0;
        end else if (i_load) begin
            r_x        <= '0;
            r_y        <= '0;
            r_org_real <= i_origin_real;
            r_step     <= i_step;
            r_cur_real <= i_origin_real;
            r_cur_imag <= i_origin_imag;
        end else if (i_advance) begin
            if (!w_last_col) begin
                r_x        <= r_x + XW'(1);
                r_cur_real <= r_cur_real + r_step;
            end else begin
                r_x        <= '0;
                r_y        <= r_y + YW'(1);
                r_cur_real <= r_org_real;
                r_cur_imag <= r_cur_imag - r_step;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_cur_real   = r_cur_real;
    assign o_cur_imag   = r_cur_imag;
    assign o_last_col   = w_last_col;
    assign o_last_pixel = w_last_col && w_last_row;

endmodule

// File: rtl/mandelbrot_frame_scheduler.sv
// Purpose : walks a pixel grid, starts the engine per pixel, streams results.
// Latency : 4 cycles per pixel plus engine time; one pixel outstanding.
// Backpres: pix_valid/pix_ready; result held in OUTPUT until accepted.
//
// Ports: frame_start/frame_abort + cfg_* from the config front end;
// eng_* start/coordinates out and done/result in; pix_* result stream;
// busy, frame_done pulse and sticky err_timeout status.
module mandelbrot_frame_scheduler
    import mandelbrot_frame_scheduler_pkg::*;
#(
    parameter int FIXED_POINT_WIDTH = 32,
    parameter int H_RES             = 64,
    parameter int V_RES             = 48,
    parameter int ITER_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES    = 1024,
    localparam int XW   = (H_RES > 1) ? $clog2(H_RES) : 1,
    localparam int YW   = (V_RES > 1) ? $clog2(V_RES) : 1,
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         frame_start,
    input  logic                         frame_abort,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_real_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_imag_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_step,
    output logic                         eng_start,
    output logic [FIXED_POINT_WIDTH-1:0] eng_c_real,
    output logic [FIXED_POINT_WIDTH-1:0] eng_c_imag,
    input  logic                         eng_valid,
    input  logic                         eng_is_mandelbrot,
    input  logic [ITER_WIDTH-1:0]        eng_iterations,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [XW-1:0]                pix_x,
    output logic [YW-1:0]                pix_y,
    output logic [ITER_WIDTH-1:0]        pix_iterations,
    output logic                         pix_in_set,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_timeout
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WD_W-1:0]       r_wdog;
    logic [ITER_WIDTH-1:0] r_pix_iter;
    logic                  r_pix_in_set;
    logic                  r_err_timeout;
    logic                  r_frame_done;

    logic                  w_load;
    logic                  w_advance;
    logic                  w_capture;
    logic                  w_timeout;
    logic                  w_last_hs;
    logic                  w_wdog_clr;
    logic                  w_last_pixel;
    logic                  w_last_col;

    mandelbrot_coord_walker #(
        .FPW   (FIXED_POINT_WIDTH),
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_walker (
        .clk           (clk),
        .nrst          (nrst),
        .i_load        (w_load),
        .i_advance     (w_advance),
        .i_origin_real (cfg_real_origin),
        .i_origin_imag (cfg_imag_origin),
        .i_step        (cfg_step),
        .o_x           (pix_x),
        .o_y           (pix_y),
        .o_cur_real    (eng_c_real),
        .o_cur_imag    (eng_c_imag),
        .o_last_col    (w_last_col),
        .o_last_pixel  (w_last_pixel)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_last_hs   = 1'b0;
        w_wdog_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_ARM;
            end
            // The engine's done flag still reflects the previous pixel here,
            // so it is only trusted from WAIT onwards.
            ST_ARM: begin
                w_wdog_clr  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUTPUT;
                end else if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (pix_ready) begin
                    if (w_last_pixel) begin
                        w_last_hs   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort outranks everything, including a same-cycle handshake.
        if (frame_abort) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
            w_advance   = 1'b0;
            w_capture   = 1'b0;
            w_timeout   = 1'b0;
            w_last_hs   = 1'b0;
            w_wdog_clr  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wdog        <= '0;
            r_pix_iter    <= '0;
            r_pix_in_set  <= 1'b0;
            r_err_timeout <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_wdog_clr) begin
                r_wdog <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wdog <= r_wdog + WD_W'(1);
            end

            if (w_capture) begin
                r_pix_iter   <= eng_iterations;
                r_pix_in_set <= eng_is_mandelbrot;
            end else if (w_timeout) begin
                r_pix_iter   <= TIMEOUT_ITER[ITER_WIDTH-1:0];
                r_pix_in_set <= TIMEOUT_IN_SET;
            end

            if (w_load) begin
                r_err_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end

            r_frame_done <= w_last_hs;
        end
    end

    // Abort gates the strobes in its own cycle so no start or handshake leaks.
    assign eng_start      = (r_state == ST_ISSUE)  && !frame_abort;
    assign pix_valid      = (r_state == ST_OUTPUT) && !frame_abort;
    assign busy           = (r_state != ST_IDLE);
    assign pix_iterations = r_pix_iter;
    assign pix_in_set     = r_pix_in_set;
    assign err_timeout    = r_err_timeout;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
module tb_mandelbrot_frame_scheduler;

    localparam int FPW = 32;
    localparam int H   = 2;
    localparam int V   = 2;
    localparam int IW  = 8;
    localparam int TO  = 16;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            frame_start = 1'b0;
    logic            frame_abort = 1'b0;
    logic [FPW-1:0]  cfg_real_origin = '0;
    logic [FPW-1:0]  cfg_imag_origin = '0;
    logic [FPW-1:0]  cfg_step = '0;
    logic            eng_start;
    logic [FPW-1:0]  eng_c_real;
    logic [FPW-1:0]  eng_c_imag;
    logic            eng_valid = 1'b0;
    logic            eng_is_mandelbrot = 1'b0;
    logic [IW-1:0]   eng_iterations = '0;
    logic            pix_valid;
    logic            pix_ready = 1'b0;
    logic [0:0]      pix_x;
    logic [0:0]      pix_y;
    logic [IW-1:0]   pix_iterations;
    logic            pix_in_set;
    logic            busy;
    logic            frame_done;
    logic            err_timeout;

    mandelbrot_frame_scheduler #(
        .FIXED_POINT_WIDTH (FPW),
        .H_RES             (H),
        .V_RES             (V),
        .ITER_WIDTH        (IW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .frame_start       (frame_start),
        .frame_abort       (frame_abort),
        .cfg_real_origin   (cfg_real_origin),
        .cfg_imag_origin   (cfg_imag_origin),
        .cfg_step          (cfg_step),
        .eng_start         (eng_start),
        .eng_c_real        (eng_c_real),
        .eng_c_imag        (eng_c_imag),
        .eng_valid         (eng_valid),
        .eng_is_mandelbrot (eng_is_mandelbrot),
        .eng_iterations    (eng_iterations),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_x             (pix_x),
        .pix_y             (pix_y),
        .pix_iterations    (pix_iterations),
        .pix_in_set        (pix_in_set),
        .busy              (busy),
        .frame_done        (frame_done),
        .err_timeout       (err_timeout)
    );

    initial forever #5 clk = ~clk;

    // Per-pixel record: engine answer to return (input) and expected outputs.
    typedef struct {
        logic [7:0]  eng_iter;
        logic        eng_set;
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        int          exp_x;
        int          exp_y;
    } vec_t;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
    } start_t;

    typedef struct {
        int         x;
        int         y;
        logic [7:0] it;
        logic       s;
    } pix_t;

    vec_t   vec[4];
    start_t q_start[$];
    pix_t   q_pix[$];
    int     done_cnt = 0;

    int     n_cmp  = 0;
    int     n_fail = 0;

    // Engine model: valid rises eng_delay cycles after the start cycle
    // (0 = never). In stale mode the old valid is held through ISSUE/ARM.
    int     eng_delay = 4;
    bit     stale = 1'b0;
    int     since = 0;
    bit     active = 1'b0;
    int     n_start = 0;

    initial forever begin
        @(negedge clk);
        if (pix_valid && pix_ready) begin
            pix_t p;
            p.x  = int'(pix_x);
            p.y  = int'(pix_y);
            p.it = pix_iterations;
            p.s  = pix_in_set;
            q_pix.push_back(p);
        end
        if (frame_done) done_cnt++;
        if (eng_start) begin
            start_t s;
            s.re = eng_c_real;
            s.im = eng_c_imag;
            q_start.push_back(s);
            since  = 0;
            active = 1'b1;
            if (!stale) eng_valid = 1'b0;
        end else if (active) begin
            since++;
            if (stale && since == 2) eng_valid = 1'b0;
            if (since == eng_delay) begin
                eng_valid         = 1'b1;
                eng_iterations    = vec[n_start % 4].eng_iter;
                eng_is_mandelbrot = vec[n_start % 4].eng_set;
                n_start++;
                active = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tbl_basic();
        vec[0] = '{8'h20, 1'b0, 32'hE000_0000, 32'h1000_0000, 0, 0};
        vec[1] = '{8'h21, 1'b1, 32'hF000_0000, 32'h1000_0000, 1, 0};
        vec[2] = '{8'h22, 1'b0, 32'hE000_0000, 32'h0000_0000, 0, 1};
        vec[3] = '{8'h23, 1'b1, 32'hF000_0000, 32'h0000_0000, 1, 1};
    endtask

    task automatic tbl_cfg2();
        vec[0] = '{8'h05, 1'b1, 32'h0800_0000, 32'hF800_0000, 0, 0};
        vec[1] = '{8'h06, 1'b1, 32'h0C00_0000, 32'hF800_0000, 1, 0};
        vec[2] = '{8'h07, 1'b0, 32'h0800_0000, 32'hF400_0000, 0, 1};
        vec[3] = '{8'h08, 1'b0, 32'h0C00_0000, 32'hF400_0000, 1, 1};
    endtask

    task automatic tbl_stale();
        vec[0] = '{8'h41, 1'b1, 32'hE000_0000, 32'h1000_0000, 0, 0};
        vec[1] = '{8'h42, 1'b0, 32'hF000_0000, 32'h1000_0000, 1, 0};
        vec[2] = '{8'h43, 1'b1, 32'hE000_0000, 32'h0000_0000, 0, 1};
        vec[3] = '{8'h44, 1'b0, 32'hF000_0000, 32'h0000_0000, 1, 1};
    endtask

    task automatic start_frame(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st);
        cfg_real_origin = re;
        cfg_imag_origin = im;
        cfg_step        = st;
        n_start         = 0;
        done_cnt        = 0;
        q_start.delete();
        q_pix.delete();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic wait_pix(input string nm, input int budget);
        for (int i = 0; i < budget && !pix_valid; i++) cyc();
        chk({nm, "_pix_valid"}, pix_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
        cyc();
        cyc();
    endtask

    task automatic run_frame(input string tag);
        wait_done(300);
        chk({tag, "_frame_done_cnt"}, done_cnt, 1);
        chk({tag, "_n_starts"}, q_start.size(), 4);
        chk({tag, "_n_pixels"}, q_pix.size(), 4);
        chk({tag, "_busy_end"}, busy, 0);
        for (int i = 0; i < 4; i++) begin
            if (i < q_start.size()) begin
                chk($sformatf("%s_re%0d", tag, i), q_start[i].re, vec[i].exp_re);
                chk($sformatf("%s_im%0d", tag, i), q_start[i].im, vec[i].exp_im);
            end
            if (i < q_pix.size()) begin
                chk($sformatf("%s_x%0d", tag, i), q_pix[i].x, vec[i].exp_x);
                chk($sformatf("%s_y%0d", tag, i), q_pix[i].y, vec[i].exp_y);
                chk($sformatf("%s_iter%0d", tag, i), q_pix[i].it, vec[i].eng_iter);
                chk($sformatf("%s_set%0d", tag, i), q_pix[i].s, vec[i].eng_set);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c_real"}, eng_c_real, 0);
        chk({tag, "_c_imag"}, eng_c_imag, 0);
        chk({tag, "_ctl"}, {eng_start, pix_valid, pix_x, pix_y, pix_iterations,
                            pix_in_set, busy, frame_done, err_timeout}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int   bad;
        int   k;
        logic err17;

        // Reset state
        #3;
        chk_all_zero("reset");
        cyc();
        nrst = 1'b1;
        cyc();
        chk("idle_busy", busy, 0);

        // Basic 2x2 frame
        tbl_basic();
        pix_ready = 1'b1;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        chk("basic_first_eng_start", eng_start, 1);
        run_frame("basic");

        // Backpressure on pixel (0,0), stray frame_start while busy
        pix_ready = 1'b0;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        wait_pix("bp", 100);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(pix_valid === 1'b1 && pix_x === 1'b0 && pix_y === 1'b0 &&
                  pix_iterations === vec[0].eng_iter && pix_in_set === vec[0].eng_set &&
                  eng_start === 1'b0 && busy === 1'b1)) bad++;
            if (i == 4) begin
                cfg_real_origin = 32'h1234_0000;
                cfg_imag_origin = 32'h0567_0000;
                cfg_step        = 32'h0001_0000;
                frame_start     = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            cyc();
        end
        frame_start = 1'b0;
        chk("bp_stable_bad_cycles", bad, 0);
        chk("bp_no_extra_start", q_start.size(), 1);
        pix_ready = 1'b1;
        cyc();
        pix_ready = 1'b0;
        chk("bp_valid_drop", pix_valid, 0);
        chk("bp_next_start", eng_start, 1);
        chk("bp_x_adv", pix_x, 1);
        chk("bp_next_re", eng_c_real, 32'hF000_0000);
        chk("bp_next_im", eng_c_imag, 32'h1000_0000);

        // Abort together with the handshake on pixel (1,0)
        wait_pix("abort", 100);
        chk("abort_pix_x", pix_x, 1);
        chk("abort_pix_y", pix_y, 0);
        chk("abort_pix_iter", pix_iterations, vec[1].eng_iter);
        frame_abort = 1'b1;
        pix_ready   = 1'b1;
        cyc();
        frame_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pix_valid", pix_valid, 0);
        cyc();
        cyc();
        cyc();
        chk("abort_no_frame_done", done_cnt, 0);

        // Restart with new configuration
        tbl_cfg2();
        start_frame(32'h0800_0000, 32'hF800_0000, 32'h0400_0000);
        chk("cfg2_first_pix_x", pix_x, 0);
        chk("cfg2_first_pix_y", pix_y, 0);
        run_frame("cfg2");

        // Stale engine valid held through ISSUE/ARM
        stale = 1'b1;
        tbl_stale();
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        run_frame("stale");
        stale = 1'b0;

        // Engine never completes: watchdog fires after 16 WAIT cycles
        eng_delay = 0;
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        k     = 0;
        err17 = 1'bx;
        for (int i = 0; i < 40 && !pix_valid; i++) begin
            cyc();
            k++;
            if (k == 17) err17 = err_timeout;
        end
        chk("to_latency", k, 18);
        chk("to_err_before", err17, 0);
        chk("to_iter", pix_iterations, 8'hFF);
        chk("to_in_set", pix_in_set, 1);
        chk("to_err", err_timeout, 1);
        wait_done(300);
        chk("to_frame_done_cnt", done_cnt, 1);
        chk("to_n_pixels", q_pix.size(), 4);
        chk("to_err_sticky_idle", err_timeout, 1);

        // err_timeout cleared by frame_start, then reset mid-WAIT
        eng_delay = 4;
        tbl_basic();
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        chk("err_cleared", err_timeout, 0);
        cyc();
        cyc();
        chk("midwait_busy", busy, 1);
        chk("midwait_re", eng_c_real, 32'hE000_0000);
        #2;
        nrst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        cyc();
        cyc();
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("post_reset_busy", busy, 0);
        chk("post_reset_err", err_timeout, 0);

        // Frame after reset behaves as from power-up
        tbl_basic();
        start_frame(32'hE000_0000, 32'h1000_0000, 32'h1000_0000);
        run_frame("pwrup");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
